// File: rtl/cache_refill_controller.sv
// Miss-path sequencer: victim selection, memory fetch and a single-cycle fill strobe.
// Optional CACHE_REFILL_INVALID_FIRST_EN: prefer the lowest-index invalid way over round-robin.
module cache_refill_controller #(
  parameter int NWAYS      = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lookup_valid,
  input  logic [ADDR_WIDTH-1:0]    lookup_addr,
  input  logic                     hit,
  input  logic [NWAYS-1:0]         way_valid,
  output logic                     lookup_ready,
  output logic                     mem_req_valid,
  output logic [ADDR_WIDTH-1:0]    mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_resp_valid,
  input  logic [LINE_WIDTH-1:0]    mem_resp_data,
  output logic                     enable_write,
  output logic [$clog2(NWAYS)-1:0] way_to_write,
  output logic [LINE_WIDTH-1:0]    fill_data,
  output logic                     busy,
  output logic                     refill_done
);

  localparam int WAY_W = $clog2(NWAYS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } state_e;

  state_e           state_r;
  logic [WAY_W-1:0] rr_ptr_r;
  logic [WAY_W-1:0] victim_r;
  logic             from_rr_r;
  logic [WAY_W-1:0] rr_next_s;
  logic [WAY_W-1:0] victim_s;
  logic             from_rr_s;

  assign rr_next_s = (rr_ptr_r == WAY_W'(NWAYS - 1)) ? {WAY_W{1'b0}} : rr_ptr_r + WAY_W'(1);

`ifdef CACHE_REFILL_INVALID_FIRST_EN
  logic [WAY_W-1:0] inv_idx_s;
  logic             any_invalid_s;

  // Victim choice: lowest invalid way wins, otherwise the round-robin pointer
  always_comb begin
    inv_idx_s     = {WAY_W{1'b0}};
    any_invalid_s = ~(&way_valid);
    for (int i = NWAYS - 1; i >= 0; i--) begin
      inv_idx_s = way_valid[i] ? inv_idx_s : WAY_W'(i);
    end
    if (any_invalid_s) begin
      victim_s  = inv_idx_s;
      from_rr_s = 1'b0;
    end else begin
      victim_s  = rr_ptr_r;
      from_rr_s = 1'b1;
    end
  end
`else
  logic unused_way_valid_s;
  assign unused_way_valid_s = ^way_valid;

  // Victim choice: always the round-robin pointer
  always_comb begin
    victim_s  = rr_ptr_r;
    from_rr_s = 1'b1;
  end
`endif

  // Refill FSM with registered outputs; strobes default low and pulse only on entry to FILL
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      rr_ptr_r      <= {WAY_W{1'b0}};
      victim_r      <= {WAY_W{1'b0}};
      from_rr_r     <= 1'b0;
      lookup_ready  <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= {ADDR_WIDTH{1'b0}};
      enable_write  <= 1'b0;
      way_to_write  <= {WAY_W{1'b0}};
      fill_data     <= {LINE_WIDTH{1'b0}};
      busy          <= 1'b0;
      refill_done   <= 1'b0;
    end else begin
      enable_write <= 1'b0;
      refill_done  <= 1'b0;
      way_to_write <= {WAY_W{1'b0}};
      case (state_r)
        IDLE: begin
          if (lookup_valid && !hit) begin
            state_r       <= REQ;
            mem_req_addr  <= lookup_addr;
            victim_r      <= victim_s;
            from_rr_r     <= from_rr_s;
            mem_req_valid <= 1'b1;
            lookup_ready  <= 1'b0;
            busy          <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state_r       <= WAIT;
            mem_req_valid <= 1'b0;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state_r      <= FILL;
            fill_data    <= mem_resp_data;
            enable_write <= 1'b1;
            refill_done  <= 1'b1;
            way_to_write <= victim_r;
          end else begin
            state_r <= WAIT;
          end
        end
        FILL: begin
          state_r      <= IDLE;
          lookup_ready <= 1'b1;
          busy         <= 1'b0;
          if (from_rr_r) begin
            rr_ptr_r <= rr_next_s;
          end else begin
            rr_ptr_r <= rr_ptr_r;
          end
        end
        default: begin
          state_r       <= IDLE;
          lookup_ready  <= 1'b1;
          mem_req_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_controller.sv
// Randomized self-checking bench for cache_refill_controller against a transaction-level model.
module tb_cache_refill_controller;

  localparam int NWAYS = 5;
  localparam int AW    = 32;
  localparam int LW    = 32;
  localparam int WW    = $clog2(NWAYS);

  logic             clk = 1'b0;
  logic             rst;
  logic             lookup_valid;
  logic [AW-1:0]    lookup_addr;
  logic             hit;
  logic [NWAYS-1:0] way_valid;
  logic             lookup_ready;
  logic             mem_req_valid;
  logic [AW-1:0]    mem_req_addr;
  logic             mem_req_ready;
  logic             mem_resp_valid;
  logic [LW-1:0]    mem_resp_data;
  logic             enable_write;
  logic [WW-1:0]    way_to_write;
  logic [LW-1:0]    fill_data;
  logic             busy;
  logic             refill_done;

  int n_cmp = 0;
  int n_err = 0;
  int rr_model = 0;

  cache_refill_controller #(.NWAYS(NWAYS), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .hit(hit),
    .way_valid(way_valid), .lookup_ready(lookup_ready), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .enable_write(enable_write), .way_to_write(way_to_write),
    .fill_data(fill_data), .busy(busy), .refill_done(refill_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      lookup_valid   = 1'($urandom_range(0, 1));
      hit            = 1'b1;
      lookup_addr    = $urandom;
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_data  = $urandom;
      mem_req_ready  = 1'($urandom_range(0, 1));
      tick;
      check_val("idle_ready", lookup_ready, 1);
      check_val("idle_req", mem_req_valid, 0);
      check_val("idle_busy", busy, 0);
      check_val("idle_we", enable_write, 0);
    end
    lookup_valid   = 1'b0;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
  endtask

  task automatic refill(input logic [AW-1:0] addr, input logic [LW-1:0] data,
                        input logic [NWAYS-1:0] wv, input int stall, input int delay);
    int exp_victim;
    bit adv;
    exp_victim = rr_model;
    adv = 1'b1;
`ifdef CACHE_REFILL_INVALID_FIRST_EN
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (!wv[i]) begin
        exp_victim = i;
        adv = 1'b0;
      end
    end
`endif
    lookup_valid   = 1'b1;
    hit            = 1'b0;
    lookup_addr    = addr;
    way_valid      = wv;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'($urandom_range(0, 1));
    mem_resp_data  = $urandom;
    tick;
    check_val("req_valid", mem_req_valid, 1);
    check_val("req_addr", mem_req_addr, addr);
    check_val("req_lookup_ready", lookup_ready, 0);
    check_val("req_busy", busy, 1);
    // a stalled upstream keeps presenting lookups; all must be ignored
    lookup_addr  = $urandom;
    lookup_valid = 1'($urandom_range(0, 1));
    hit          = 1'($urandom_range(0, 1));
    way_valid    = NWAYS'($urandom);
    for (int s = 0; s < stall; s++) begin
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_data  = $urandom;
      tick;
      check_val("stall_valid", mem_req_valid, 1);
      check_val("stall_addr", mem_req_addr, addr);
      check_val("stall_we", enable_write, 0);
    end
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'($urandom_range(0, 1));
    tick;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    check_val("wait_req_dropped", mem_req_valid, 0);
    check_val("wait_busy", busy, 1);
    check_val("wait_we", enable_write, 0);
    for (int d = 0; d < delay; d++) begin
      mem_req_ready = 1'($urandom_range(0, 1));
      tick;
      check_val("wait_hold_we", enable_write, 0);
      check_val("wait_hold_req", mem_req_valid, 0);
      check_val("wait_hold_busy", busy, 1);
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    tick;
    check_val("fill_we", enable_write, 1);
    check_val("fill_done", refill_done, 1);
    check_val("fill_way", way_to_write, exp_victim);
    check_val("fill_data", fill_data, data);
    check_val("fill_req", mem_req_valid, 0);
    if (adv) rr_model = (rr_model + 1) % NWAYS;
    lookup_valid   = 1'b0;
    mem_resp_valid = 1'($urandom_range(0, 1));
    mem_resp_data  = $urandom;
    tick;
    mem_resp_valid = 1'b0;
    check_val("post_we", enable_write, 0);
    check_val("post_done", refill_done, 0);
    check_val("post_way", way_to_write, 0);
    check_val("post_ready", lookup_ready, 1);
    check_val("post_busy", busy, 0);
    check_val("post_data_kept", fill_data, data);
  endtask

  task automatic reset_mid_wait;
    lookup_valid  = 1'b1;
    hit           = 1'b0;
    lookup_addr   = $urandom;
    way_valid     = '1;
    mem_req_ready = 1'b1;
    tick;
    lookup_valid  = 1'b0;
    tick;
    mem_req_ready = 1'b0;
    check_val("rw_in_wait", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    rr_model = 0;
    check_val("rw_busy", busy, 0);
    check_val("rw_ready", lookup_ready, 1);
    check_val("rw_req", mem_req_valid, 0);
    check_val("rw_addr", mem_req_addr, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = $urandom;
    tick;
    mem_resp_valid = 1'b0;
    check_val("rw_no_we", enable_write, 0);
    check_val("rw_no_done", refill_done, 0);
    check_val("rw_still_idle", busy, 0);
    check_val("rw_fill_clear", fill_data, 0);
  endtask

  initial begin
    rst = 1'b1;
    lookup_valid = 1'b0; lookup_addr = '0; hit = 1'b0; way_valid = '1;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick;
    tick;
    check_val("rst_ready", lookup_ready, 1);
    check_val("rst_req", mem_req_valid, 0);
    check_val("rst_addr", mem_req_addr, 0);
    check_val("rst_we", enable_write, 0);
    check_val("rst_way", way_to_write, 0);
    check_val("rst_fill", fill_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", refill_done, 0);
    rst = 1'b0;

    refill(32'h0000_0100, 32'hDEAD_BEEF, 5'b11111, 0, 0);
    for (int k = 0; k < 5; k++) begin
      refill($urandom, $urandom, 5'b11111, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    refill($urandom, $urandom, 5'b11111, 4, 1);
    refill($urandom, $urandom, 5'b10111, 0, 0);
    refill($urandom, $urandom, 5'b11111, 1, 0);
    idle_cycles(3);
    reset_mid_wait();
    refill($urandom, $urandom, 5'b11111, 0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [NWAYS-1:0] wv;
      wv = ($urandom_range(0, 1) == 0) ? {NWAYS{1'b1}} : NWAYS'($urandom);
      idle_cycles(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 9) == 0) reset_mid_wait();
      refill($urandom, $urandom, wv, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_refill_controller.md
# cache_refill_controller

Sequencing FSM for the set-associative cache's miss path. On a lookup miss it selects a victim way, fetches the line from memory over a valid/ready request and valid-only response, and then issues a single-cycle write strobe. The strobe (`enable_write`, `way_to_write`) drives the per-way write-enable mask generator. Only one miss is outstanding at a time, and new lookups are stalled while a refill is in flight.

## Interface
- `NWAYS`, default 5: number of ways; any value ≥ 2, not limited to powers of two.
- `ADDR_WIDTH`, default 32: width of the lookup and memory addresses.
- `LINE_WIDTH`, default 32: width of the fill data.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `lookup_valid` in 1: a lookup result is presented this cycle.
- `lookup_addr` in ADDR_WIDTH: address of that lookup.
- `hit` in 1: the lookup hit; qualified by `lookup_valid`.
- `way_valid` in NWAYS: per-way valid bits of the indexed set.
- `lookup_ready` out 1: controller is able to accept a lookup (high only in IDLE).
- `mem_req_valid` out 1: memory read request is pending.
- `mem_req_addr` out ADDR_WIDTH: latched miss address.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_resp_valid` in 1: fill data is valid this cycle.
- `mem_resp_data` in LINE_WIDTH: fill data.
- `enable_write` out 1: one-cycle fill write strobe.
- `way_to_write` out $clog2(NWAYS): victim way index.
- `fill_data` out LINE_WIDTH: latched response data.
- `busy` out 1: state is not IDLE.
- `refill_done` out 1: one-cycle pulse, coincident with `enable_write`.

## Operation
- States: IDLE, REQ, WAIT, FILL. All outputs are decoded from registered state, address and data.
- IDLE:
  - `lookup_valid && hit`: stay in IDLE; no side effects.
  - `lookup_valid && !hit`: latch `lookup_addr` and the victim, then go to REQ.
  - `lookup_valid` low: stay in IDLE.
- REQ: hold `mem_req_valid=1` with a stable `mem_req_addr` until `mem_req_ready`, then go to WAIT.
- WAIT: on `mem_resp_valid`, latch `mem_resp_data` into `fill_data` and go to FILL.
- FILL:
  - Assert `enable_write=1` and `refill_done=1` for exactly one cycle, with `way_to_write` = latched victim.
  - Next state is IDLE.
- Victim choice: round-robin pointer `rr_ptr`.
  - `rr_ptr` increments modulo NWAYS, so NWAYS-1 wraps to 0.
  - It increments only on a FILL whose victim came from `rr_ptr`.
- `mem_resp_valid` is ignored outside WAIT, with no state change.
- `lookup_valid` is ignored outside IDLE; the upstream stage must hold the lookup while `lookup_ready=0`.
- Reset, including mid-refill: state returns to IDLE and `rr_ptr=0`.
  - Any latched request is discarded; no `enable_write` is issued for it.
  - A response arriving after reset is ignored.
- Reset values:
  - `lookup_ready=1`.
  - All other outputs 0: `mem_req_valid`, `mem_req_addr`, `enable_write`, `way_to_write`, `fill_data`, `busy`, `refill_done`.
- `way_to_write` reads 0 whenever `enable_write=0`.

## Timing
- A miss is sampled at edge N; `mem_req_valid` is high from cycle N+1.
- If `mem_req_ready` is high in cycle N+1, the state is WAIT in N+2.
- A response sampled in cycle K gives `enable_write` in cycle K+1.
- Minimum miss-to-write latency is 3 cycles (N+1 REQ, N+2 WAIT with response, N+3 FILL).
- `lookup_ready` returns high in the cycle after FILL, so back-to-back misses are spaced by at least 4 cycles.
- Request stall: `mem_req_valid` and `mem_req_addr` stay constant for as many cycles as `mem_req_ready=0`.

## Configuration
- `CACHE_REFILL_INVALID_FIRST_EN` defined:
  - If any bit of `way_valid` sampled at the miss is 0, the victim is the lowest-index invalid way and `rr_ptr` does not advance.
  - Otherwise the victim is `rr_ptr`.
- Not defined: `way_valid` is ignored and the victim is always `rr_ptr`.

## Test plan
- Reset, then a miss at addr 0x100 with `mem_req_ready=1` and the response 0xDEADBEEF one cycle later:
  - `mem_req_addr`=0x100 for one cycle.
  - In the FILL cycle: `enable_write=1`, `way_to_write=0`, `fill_data`=0xDEADBEEF, `refill_done=1`.
- Six consecutive misses with NWAYS=5 and `way_valid`=5'b11111: victims are 0,1,2,3,4,0 (wrap).
- `mem_req_ready` held low for 4 cycles: `mem_req_valid` stays high with a constant address for 4 cycles; exactly one request handshake occurs.
- Macro defined with `way_valid`=5'b10111: victim is 3 and `rr_ptr` is unchanged. Macro undefined with the same input: victim is `rr_ptr`.
- `rst` asserted during WAIT, then `mem_resp_valid` pulsed:
  - No `enable_write` is issued.
  - `busy=0` and `lookup_ready=1` from the cycle after reset.
- A hit lookup in IDLE and a `lookup_valid` during WAIT: neither produces any state change or memory request.
